// File: rtl/ram_pkg.sv
// Shared types for the ping-pong RAM manager: per-RAM slot states and FSM states.
package ram_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        WRITING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } ram_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rd_state_t;

    function automatic logic [1:0] count_full(input ram_state_t a, input ram_state_t b);
        return {1'b0, (a == FULL)} + {1'b0, (b == FULL)};
    endfunction

endpackage

// File: rtl/ram_manage_if.sv
// Handshake bundle between the ping-pong manager and the RAM write/read controllers.
interface ram_manage_if;
    logic wr_finish_0;
    logic wr_finish_1;
    logic rd_finish_0;
    logic rd_finish_1;
    logic wr_command;
    logic rd_command;
    logic wr_ram_number;
    logic rd_ram_number;

    modport manager (
        input  wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1,
        output wr_command, rd_command, wr_ram_number, rd_ram_number
    );

    modport controller (
        output wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1,
        input  wr_command, rd_command, wr_ram_number, rd_ram_number
    );
endinterface

// File: rtl/ram_slot_state.sv
// Lifecycle of one RAM buffer: EMPTY -> WRITING -> FULL -> READING -> EMPTY.
module ram_slot_state
    import ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_start,
    input  logic       wr_done,
    input  logic       rd_start,
    input  logic       rd_done,
    output ram_state_t state
);

    ram_state_t state_r;
    ram_state_t state_next_s;

    // Next slot state; each transition only fires from its own source state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY:   if (wr_start) state_next_s = WRITING; else state_next_s = EMPTY;
            WRITING: if (wr_done)  state_next_s = FULL;    else state_next_s = WRITING;
            FULL:    if (rd_start) state_next_s = READING; else state_next_s = FULL;
            READING: if (rd_done)  state_next_s = EMPTY;   else state_next_s = READING;
            default: state_next_s = EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= EMPTY;
        else     state_r <= state_next_s;
    end

    assign state = state_r;

endmodule

// File: rtl/ram_pingpong_mgr.sv
// Ping-pong manager for two frame RAMs: alternates writes and reads with back-pressure.
// Optional completed-frame counters are enabled with macro PP_FRAME_CNT_EN.
module ram_pingpong_mgr
    import ram_pkg::*;
#(
    parameter int CNT_WIDTH = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_req,
    input  logic                 rd_ready,
    input  logic                 wr_finish_0,
    input  logic                 wr_finish_1,
    input  logic                 rd_finish_0,
    input  logic                 rd_finish_1,
    output logic                 wr_command,
    output logic                 rd_command,
    output logic                 wr_ram_number,
    output logic                 rd_ram_number,
    output logic [1:0]           full_cnt
`ifdef PP_FRAME_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] wr_frame_cnt,
    output logic [CNT_WIDTH-1:0] rd_frame_cnt
`endif
);

    ram_manage_if mgr_if ();

    wr_state_t  wr_state_r, wr_next_s;
    rd_state_t  rd_state_r, rd_next_s;
    logic       wr_ptr_r, rd_ptr_r, ready_r;
    logic       wr_command_r, rd_command_r, wr_ram_number_r, rd_ram_number_r;
    logic [1:0] full_cnt_r;
    logic       wr_issue_s, wr_done_s, rd_issue_s, rd_done_s;
    logic       wr_fin_sel_s, rd_fin_sel_s;
    ram_state_t slot0_state_s, slot1_state_s, wr_slot_s, rd_slot_s;

    assign mgr_if.wr_finish_0 = wr_finish_0;
    assign mgr_if.wr_finish_1 = wr_finish_1;
    assign mgr_if.rd_finish_0 = rd_finish_0;
    assign mgr_if.rd_finish_1 = rd_finish_1;
    assign mgr_if.wr_command    = wr_command_r;
    assign mgr_if.rd_command    = rd_command_r;
    assign mgr_if.wr_ram_number = wr_ram_number_r;
    assign mgr_if.rd_ram_number = rd_ram_number_r;
    assign wr_command    = mgr_if.wr_command;
    assign rd_command    = mgr_if.rd_command;
    assign wr_ram_number = mgr_if.wr_ram_number;
    assign rd_ram_number = mgr_if.rd_ram_number;
    assign full_cnt      = full_cnt_r;

    // Only the finish pulse of the currently selected RAM is ever looked at.
    assign wr_fin_sel_s = wr_ptr_r ? mgr_if.wr_finish_1 : mgr_if.wr_finish_0;
    assign rd_fin_sel_s = rd_ptr_r ? mgr_if.rd_finish_1 : mgr_if.rd_finish_0;
    assign wr_slot_s    = wr_ptr_r ? slot1_state_s : slot0_state_s;
    assign rd_slot_s    = rd_ptr_r ? slot1_state_s : slot0_state_s;

    ram_slot_state u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .wr_start (wr_issue_s & ~wr_ptr_r),
        .wr_done  (wr_done_s  & ~wr_ptr_r),
        .rd_start (rd_issue_s & ~rd_ptr_r),
        .rd_done  (rd_done_s  & ~rd_ptr_r),
        .state    (slot0_state_s)
    );

    ram_slot_state u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .wr_start (wr_issue_s & wr_ptr_r),
        .wr_done  (wr_done_s  & wr_ptr_r),
        .rd_start (rd_issue_s & rd_ptr_r),
        .rd_done  (rd_done_s  & rd_ptr_r),
        .state    (slot1_state_s)
    );

    // Write FSM; ready_r keeps the first cycle after reset command-free.
    always_comb begin
        wr_next_s  = wr_state_r;
        wr_issue_s = 1'b0;
        wr_done_s  = 1'b0;
        case (wr_state_r)
            W_IDLE: begin
                if (ready_r && wr_req && (wr_slot_s == EMPTY)) begin
                    wr_issue_s = 1'b1;
                    wr_next_s  = W_BUSY;
                end else begin
                    wr_next_s  = W_IDLE;
                end
            end
            W_BUSY: begin
                if (wr_fin_sel_s) begin
                    wr_done_s = 1'b1;
                    wr_next_s = W_IDLE;
                end else begin
                    wr_next_s = W_BUSY;
                end
            end
            default: wr_next_s = W_IDLE;
        endcase
    end

    // Read FSM, mirroring the write side on FULL slots.
    always_comb begin
        rd_next_s  = rd_state_r;
        rd_issue_s = 1'b0;
        rd_done_s  = 1'b0;
        case (rd_state_r)
            R_IDLE: begin
                if (ready_r && rd_ready && (rd_slot_s == FULL)) begin
                    rd_issue_s = 1'b1;
                    rd_next_s  = R_BUSY;
                end else begin
                    rd_next_s  = R_IDLE;
                end
            end
            R_BUSY: begin
                if (rd_fin_sel_s) begin
                    rd_done_s = 1'b1;
                    rd_next_s = R_IDLE;
                end else begin
                    rd_next_s = R_BUSY;
                end
            end
            default: rd_next_s = R_IDLE;
        endcase
    end

    // FSM state, pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r         <= 1'b0;
            wr_state_r      <= W_IDLE;
            rd_state_r      <= R_IDLE;
            wr_ptr_r        <= 1'b0;
            rd_ptr_r        <= 1'b0;
            wr_command_r    <= 1'b0;
            rd_command_r    <= 1'b0;
            wr_ram_number_r <= 1'b0;
            rd_ram_number_r <= 1'b0;
            full_cnt_r      <= 2'd0;
        end else begin
            ready_r      <= 1'b1;
            wr_state_r   <= wr_next_s;
            rd_state_r   <= rd_next_s;
            wr_command_r <= wr_issue_s;
            rd_command_r <= rd_issue_s;
            full_cnt_r   <= count_full(slot0_state_s, slot1_state_s);
            if (wr_issue_s) wr_ram_number_r <= wr_ptr_r;
            if (rd_issue_s) rd_ram_number_r <= rd_ptr_r;
            if (wr_done_s)  wr_ptr_r <= ~wr_ptr_r;
            if (rd_done_s)  rd_ptr_r <= ~rd_ptr_r;
        end
    end

`ifdef PP_FRAME_CNT_EN
    logic [CNT_WIDTH-1:0] wr_frame_cnt_r, rd_frame_cnt_r;

    // Completed-frame counters, wrapping naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_frame_cnt_r <= {CNT_WIDTH{1'b0}};
            rd_frame_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (wr_done_s) wr_frame_cnt_r <= wr_frame_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (rd_done_s) rd_frame_cnt_r <= rd_frame_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign wr_frame_cnt = wr_frame_cnt_r;
    assign rd_frame_cnt = rd_frame_cnt_r;
`else
    // Counters compiled out; the width parameter is still range-checked.
    if (CNT_WIDTH < 1) begin : g_cnt_width_invalid
        logic cnt_width_invalid_s;
        assign cnt_width_invalid_s = 1'b1;
    end
`endif

endmodule

// File: tb/tb_ram_pingpong_mgr.sv
// Directed self-checking bench for ram_pingpong_mgr (counter checks when PP_FRAME_CNT_EN is set).
module tb_ram_pingpong_mgr;
    import ram_pkg::*;

    logic       clk;
    logic       rst;
    logic       wr_req, rd_ready;
    logic       wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1;
    logic       wr_command, rd_command, wr_ram_number, rd_ram_number;
    logic [1:0] full_cnt;
`ifdef PP_FRAME_CNT_EN
    logic [15:0] wr_frame_cnt, rd_frame_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ram_pingpong_mgr #(.CNT_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_req        (wr_req),
        .rd_ready      (rd_ready),
        .wr_finish_0   (wr_finish_0),
        .wr_finish_1   (wr_finish_1),
        .rd_finish_0   (rd_finish_0),
        .rd_finish_1   (rd_finish_1),
        .wr_command    (wr_command),
        .rd_command    (rd_command),
        .wr_ram_number (wr_ram_number),
        .rd_ram_number (rd_ram_number),
        .full_cnt      (full_cnt)
`ifdef PP_FRAME_CNT_EN
        ,
        .wr_frame_cnt  (wr_frame_cnt),
        .rd_frame_cnt  (rd_frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_slots(input string tag, input ram_state_t s0, input ram_state_t s1);
        chk({tag, "_ram0"}, 16'(dut.slot0_state_s), 16'(s0));
        chk({tag, "_ram1"}, 16'(dut.slot1_state_s), 16'(s1));
    endtask

    int   wr_log[4];
    int   rd_log[4];
    int   nw, nr, wr_left, rd_left, overlap, bp_seen;
    logic wr_pend, rd_pend, wr_num, rd_num;

    initial begin
        rst = 1'b1; wr_req = 1'b0; rd_ready = 1'b0;
        wr_finish_0 = 1'b0; wr_finish_1 = 1'b0; rd_finish_0 = 1'b0; rd_finish_1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wr_cmd", 16'(wr_command), 16'd0);
        chk("rst_rd_cmd", 16'(rd_command), 16'd0);
        chk("rst_wr_num", 16'(wr_ram_number), 16'd0);
        chk("rst_rd_num", 16'(rd_ram_number), 16'd0);
        chk("rst_full_cnt", 16'(full_cnt), 16'd0);

        // Single frame into RAM0; no command in the first cycle out of reset.
        rst = 1'b0; wr_req = 1'b1;
        @(negedge clk);
        chk("no_cmd_after_rst", 16'(wr_command), 16'd0);
        @(negedge clk);
        chk("wr_cmd_f0", 16'(wr_command), 16'd1);
        chk("wr_num_f0", 16'(wr_ram_number), 16'd0);
        chk_slots("writing0", WRITING, EMPTY);
        wr_req = 1'b0;
        @(negedge clk);
        chk("wr_cmd_one_cycle", 16'(wr_command), 16'd0);

        // Spurious finishes: wrong-RAM write finish and idle read finish.
        wr_finish_1 = 1'b1; rd_finish_0 = 1'b1;
        @(negedge clk);
        wr_finish_1 = 1'b0; rd_finish_0 = 1'b0;
        chk_slots("spurious", WRITING, EMPTY);
        chk("spurious_full_cnt", 16'(full_cnt), 16'd0);
        chk("spurious_rd_cmd", 16'(rd_command), 16'd0);
        repeat (7) @(negedge clk);
        wr_finish_0 = 1'b1;
        @(negedge clk);
        wr_finish_0 = 1'b0;
        chk_slots("full0", FULL, EMPTY);
        chk("full_cnt_latency", 16'(full_cnt), 16'd0);
        @(negedge clk);
        chk("full_cnt_one", 16'(full_cnt), 16'd1);

        // Back-pressure: second frame into RAM1, then no third write.
        wr_req = 1'b1;
        @(negedge clk);
        chk("wr_cmd_f1", 16'(wr_command), 16'd1);
        chk("wr_num_f1", 16'(wr_ram_number), 16'd1);
        wr_finish_1 = 1'b1;
        @(negedge clk);
        wr_finish_1 = 1'b0;
        bp_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wr_command) bp_seen++;
        end
        chk("bp_no_third_wr", 16'(bp_seen), 16'd0);
        chk("bp_full_cnt", 16'(full_cnt), 16'd2);
        rd_ready = 1'b1;
        @(negedge clk);
        chk("rd_cmd_r0", 16'(rd_command), 16'd1);
        chk("rd_num_r0", 16'(rd_ram_number), 16'd0);
        chk_slots("reading0", READING, FULL);
        rd_ready = 1'b0; rd_finish_0 = 1'b1;
        @(negedge clk);
        rd_finish_0 = 1'b0;
        chk("bp_wr_not_yet", 16'(wr_command), 16'd0);
        chk_slots("empty0", EMPTY, FULL);
        @(negedge clk);
        chk("bp_release_wr", 16'(wr_command), 16'd1);
        chk("bp_release_num", 16'(wr_ram_number), 16'd0);

        // Read RAM1 while RAM0 is being written; both finish together.
        rd_ready = 1'b1;
        @(negedge clk);
        chk("rd_cmd_r1", 16'(rd_command), 16'd1);
        chk("rd_num_r1", 16'(rd_ram_number), 16'd1);
        rd_ready = 1'b0; wr_req = 1'b0;
        wr_finish_0 = 1'b1; rd_finish_1 = 1'b1;
        @(negedge clk);
        wr_finish_0 = 1'b0; rd_finish_1 = 1'b0;
        chk_slots("simul_a", FULL, EMPTY);

        // Write RAM1 and read RAM0 at once, then wr_finish_1 with rd_finish_0.
        wr_req = 1'b1; rd_ready = 1'b1;
        @(negedge clk);
        chk("simul_wr_cmd", 16'(wr_command), 16'd1);
        chk("simul_wr_num", 16'(wr_ram_number), 16'd1);
        chk("simul_rd_cmd", 16'(rd_command), 16'd1);
        chk("simul_rd_num", 16'(rd_ram_number), 16'd0);
        wr_req = 1'b0; rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        wr_finish_1 = 1'b1; rd_finish_0 = 1'b1;
        @(negedge clk);
        wr_finish_1 = 1'b0; rd_finish_0 = 1'b0;
        chk_slots("simul_b", EMPTY, FULL);
        @(negedge clk);
        chk("simul_full_cnt", 16'(full_cnt), 16'd1);

        // Mid-frame reset while writing RAM0 with RAM1 full.
        wr_req = 1'b1;
        @(negedge clk);
        chk("pre_rst_wr_cmd", 16'(wr_command), 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_wr_cmd", 16'(wr_command), 16'd0);
        chk("midrst_full_cnt", 16'(full_cnt), 16'd0);
        chk("midrst_rd_num", 16'(rd_ram_number), 16'd0);
        chk_slots("midrst", EMPTY, EMPTY);
`ifdef PP_FRAME_CNT_EN
        chk("midrst_wr_frames", wr_frame_cnt, 16'd0);
        chk("midrst_rd_frames", rd_frame_cnt, 16'd0);
`endif
        wr_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Ping-pong: 4 frames, controllers answer 3 cycles after each command.
        wr_req = 1'b1; rd_ready = 1'b1;
        nw = 0; nr = 0; overlap = 0; wr_pend = 1'b0; rd_pend = 1'b0;
        wr_left = 0; rd_left = 0; wr_num = 1'b0; rd_num = 1'b0;
        for (int cyc = 0; cyc < 200 && !(nw == 4 && nr == 4 && !wr_pend && !rd_pend); cyc++) begin
            @(negedge clk);
            wr_finish_0 = 1'b0; wr_finish_1 = 1'b0; rd_finish_0 = 1'b0; rd_finish_1 = 1'b0;
            if (wr_command) begin
                if (nw < 4) wr_log[nw] = int'(wr_ram_number);
                nw++;
                if (rd_pend && rd_num == wr_ram_number) overlap++;
                wr_pend = 1'b1; wr_left = 3; wr_num = wr_ram_number;
                if (nw >= 4) wr_req = 1'b0;
            end else if (wr_pend) begin
                wr_left--;
                if (wr_left == 0) begin
                    if (wr_num) wr_finish_1 = 1'b1; else wr_finish_0 = 1'b1;
                    wr_pend = 1'b0;
                end
            end
            if (rd_command) begin
                if (nr < 4) rd_log[nr] = int'(rd_ram_number);
                nr++;
                if (wr_pend && wr_num == rd_ram_number) overlap++;
                rd_pend = 1'b1; rd_left = 3; rd_num = rd_ram_number;
                if (nr >= 4) rd_ready = 1'b0;
            end else if (rd_pend) begin
                rd_left--;
                if (rd_left == 0) begin
                    if (rd_num) rd_finish_1 = 1'b1; else rd_finish_0 = 1'b1;
                    rd_pend = 1'b0;
                end
            end
        end
        @(negedge clk);
        wr_finish_0 = 1'b0; wr_finish_1 = 1'b0; rd_finish_0 = 1'b0; rd_finish_1 = 1'b0;
        chk("pp_wr_frames", 16'(nw), 16'd4);
        chk("pp_rd_frames", 16'(nr), 16'd4);
        chk("pp_overlap", 16'(overlap), 16'd0);
        chk("pp_wr0", 16'(wr_log[0]), 16'd0);
        chk("pp_wr1", 16'(wr_log[1]), 16'd1);
        chk("pp_wr2", 16'(wr_log[2]), 16'd0);
        chk("pp_wr3", 16'(wr_log[3]), 16'd1);
        chk("pp_rd0", 16'(rd_log[0]), 16'd0);
        chk("pp_rd1", 16'(rd_log[1]), 16'd1);
        chk("pp_rd2", 16'(rd_log[2]), 16'd0);
        chk("pp_rd3", 16'(rd_log[3]), 16'd1);
        repeat (2) @(negedge clk);
        chk("pp_full_cnt_end", 16'(full_cnt), 16'd0);
        chk_slots("pp_end", EMPTY, EMPTY);
`ifdef PP_FRAME_CNT_EN
        chk("pp_wr_frame_cnt", wr_frame_cnt, 16'd4);
        chk("pp_rd_frame_cnt", rd_frame_cnt, 16'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
